// File: rtl/song_sequencer_pkg.sv
// Shared widths, state encoding, ROM word layout and song tables for the note sequencer.
package song_sequencer_pkg;

    localparam int unsigned NUM_SONGS = 8;
    localparam int unsigned SONG_W    = $clog2(NUM_SONGS);
    localparam int unsigned IDX_W     = 11;
    localparam int unsigned MAX_NOTES = 2 ** IDX_W;
    localparam int unsigned PITCH_W   = 7;
    localparam int unsigned DUR_W     = 8;
    localparam int unsigned ADDR_W    = SONG_W + IDX_W;

    localparam logic [DUR_W-1:0]   END_DUR    = '0;
    localparam logic [PITCH_W-1:0] REST_PITCH = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } note_word_t;

    // Build one ROM word from a pitch and a duration.
    function automatic note_word_t mk_note(int unsigned p, int unsigned d);
        note_word_t w;
        w.pitch = PITCH_W'(p);
        w.dur   = DUR_W'(d);
        return w;
    endfunction

    // Per-song note tables; anything not listed is an end marker.
    function automatic note_word_t song_table(logic [SONG_W-1:0] song, logic [IDX_W-1:0] idx);
        note_word_t w;
        w.pitch = REST_PITCH;
        w.dur   = END_DUR;
        case (song)
            SONG_W'(0): begin
                case (idx)
                    IDX_W'(0): w = mk_note(77, 2);
                    IDX_W'(1): w = mk_note(0, 1);
                    IDX_W'(2): w = mk_note(75, 2);
                    default:   w = mk_note(0, 0);
                endcase
            end
            // Full-length song with no end marker: a repeating 16-step ramp.
            SONG_W'(1): begin
                w.pitch = PITCH_W'(60) + PITCH_W'(idx[3:0]);
                w.dur   = DUR_W'(1);
            end
            SONG_W'(2): begin
                case (idx)
                    IDX_W'(0): w = mk_note(72, 1);
                    IDX_W'(1): w = mk_note(76, 2);
                    IDX_W'(2): w = mk_note(79, 1);
                    default:   w = mk_note(0, 0);
                endcase
            end
            default: w = mk_note(0, 0);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control and note-output bundle between a controller and the song sequencer.
interface song_sequencer_if;
    import song_sequencer_pkg::*;

    logic               beat_tick;
    logic               start;
    logic               stop;
    logic               pause;
    logic               loop_en;
    logic [SONG_W-1:0]  song_sel;
    logic [PITCH_W-1:0] note_pitch;
    logic               note_on;
    logic [IDX_W-1:0]   note_index;
    logic               busy;
    logic               song_done;

    modport master (
        output beat_tick, start, stop, pause, loop_en, song_sel,
        input  note_pitch, note_on, note_index, busy, song_done
    );

    modport slave (
        input  beat_tick, start, stop, pause, loop_en, song_sel,
        output note_pitch, note_on, note_index, busy, song_done
    );

endinterface

// File: rtl/song_sequencer_rom.sv
// Song ROM: NUM_SONGS x MAX_NOTES {pitch,dur} words, one-cycle registered read.
module song_sequencer_rom
    import song_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output note_word_t        rdata
);

    // Registered read of the word at {song,index}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= song_table(addr[ADDR_W-1 -: SONG_W], addr[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Multi-song note sequencer: walks the song ROM and holds each note for its tick duration.
module song_sequencer
    import song_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    song_sequencer_if.slave bus
);

    state_t             state;
    logic               start_q;
    logic [SONG_W-1:0]  sel_q;
    logic [SONG_W-1:0]  song_q;
    logic [IDX_W-1:0]   index_q;
    logic [DUR_W-1:0]   remain;
    logic [PITCH_W-1:0] pitch_q;
    logic               note_on_q;
    logic [IDX_W-1:0]   note_index_q;
    logic               busy_q;
    logic               song_done_q;

    note_word_t         rom_q;
    logic [ADDR_W-1:0]  rom_addr;
    logic               start_ok;
    logic               tick_eff;
    logic               last_note;
    logic               end_hit;

    song_sequencer_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (rom_addr),
        .rdata (rom_q)
    );

    assign rom_addr  = {song_q, index_q};
    // A start is only taken from IDLE/DONE and never alongside stop.
    assign start_ok  = bus.start && !bus.stop && (state == ST_IDLE || state == ST_DONE);
    assign tick_eff  = bus.beat_tick && !bus.pause;
    assign last_note = (index_q == IDX_W'(MAX_NOTES - 1));
    // End of song: explicit marker, or the final table slot running out.
    assign end_hit   = ((state == ST_LOAD) && (rom_q.dur == END_DUR)) ||
                       ((state == ST_PLAY) && tick_eff && (remain == DUR_W'(1)) && last_note);

    assign bus.note_pitch = pitch_q;
    assign bus.note_on    = note_on_q;
    assign bus.note_index = note_index_q;
    assign bus.busy       = busy_q;
    assign bus.song_done  = song_done_q;

    // Sequencer FSM with duration/index counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            sel_q        <= '0;
            song_q       <= '0;
            index_q      <= '0;
            remain       <= '0;
            pitch_q      <= '0;
            note_on_q    <= 1'b0;
            note_index_q <= '0;
            busy_q       <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            note_on_q   <= 1'b0;
            song_done_q <= 1'b0;
            start_q     <= start_ok;
            if (start_ok) begin
                sel_q <= bus.song_sel;
            end

            if (bus.stop) begin
                state   <= ST_IDLE;
                busy_q  <= 1'b0;
                pitch_q <= REST_PITCH;
            end else if (end_hit) begin
                if (bus.loop_en) begin
                    index_q <= '0;
                    state   <= ST_FETCH;
                    busy_q  <= 1'b1;
                end else begin
                    state       <= ST_DONE;
                    busy_q      <= 1'b0;
                    pitch_q     <= REST_PITCH;
                    song_done_q <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start_q) begin
                            song_q  <= sel_q;
                            index_q <= '0;
                            state   <= ST_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        state        <= ST_PLAY;
                        pitch_q      <= rom_q.pitch;
                        remain       <= rom_q.dur;
                        note_index_q <= index_q;
                        note_on_q    <= (rom_q.pitch != REST_PITCH);
                    end
                    ST_PLAY: begin
                        if (tick_eff) begin
                            if (remain == DUR_W'(1)) begin
                                index_q <= index_q + IDX_W'(1);
                                state   <= ST_FETCH;
                            end else begin
                                remain <= remain - DUR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: note_on/song_done events checked against expected queue.
module tb_song_sequencer;
    import song_sequencer_pkg::*;

    typedef struct {
        bit is_done;
        int pitch;
        int index;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    song_sequencer_if bus ();

    song_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_note(input int p, input int i);
        exp_t e;
        e.is_done = 1'b0;
        e.pitch   = p;
        e.index   = i;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.pitch   = 0;
        e.index   = 0;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One beat_tick, then three idle cycles (next note is playing on return).
    task automatic do_tick();
        bus.beat_tick = 1'b1;
        cyc();
        bus.beat_tick = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    // Start a song and wait until its first note is in PLAY.
    task automatic start_song(input int sel);
        bus.song_sel = SONG_W'(sel);
        bus.start    = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    // Monitor: pop one expected event per note_on / song_done strobe.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.note_on === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected note_on: pitch %0d index %0d, none expected",
                             bus.note_pitch, bus.note_index);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event kind (note_on)", 0, int'(mon_e.is_done));
                    check("note_on pitch", int'(bus.note_pitch), mon_e.pitch);
                    check("note_on index", int'(bus.note_index), mon_e.index);
                end
            end
            if (bus.song_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected song_done: got 1 expected 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event kind (song_done)", 1, int'(mon_e.is_done));
                    check("song_done pitch", int'(bus.note_pitch), 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.beat_tick = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.pause     = 1'b0;
        bus.loop_en   = 1'b0;
        bus.song_sel  = '0;
        rst_n         = 1'b0;
        cyc();
        cyc();
        check("reset pitch", int'(bus.note_pitch), 0);
        check("reset note_on", int'(bus.note_on), 0);
        check("reset index", int'(bus.note_index), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset song_done", int'(bus.song_done), 0);
        rst_n = 1'b1;
        cyc();

        // Song 0 single pass with latency and glitch-free gap checks.
        push_note(77, 0);
        push_note(75, 2);
        push_done();
        bus.song_sel = '0;
        bus.start    = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("busy before fetch", int'(bus.busy), 0);
        cyc();
        check("busy in fetch", int'(bus.busy), 1);
        cyc();
        check("note_on early", int'(bus.note_on), 0);
        cyc();
        check("note_on at start+3", int'(bus.note_on), 1);
        check("first pitch", int'(bus.note_pitch), 77);
        do_tick();
        check("77 after 1 tick", int'(bus.note_pitch), 77);
        bus.beat_tick = 1'b1;
        cyc();
        bus.beat_tick = 1'b0;
        check("pitch held in fetch", int'(bus.note_pitch), 77);
        cyc();
        check("pitch held in load", int'(bus.note_pitch), 77);
        cyc();
        check("rest pitch", int'(bus.note_pitch), 0);
        check("busy during rest", int'(bus.busy), 1);
        cyc();
        do_tick();
        check("third pitch", int'(bus.note_pitch), 75);
        check("third index", int'(bus.note_index), 2);
        do_tick();
        check("75 after 1 tick", int'(bus.note_pitch), 75);
        do_tick();
        check("pitch after done", int'(bus.note_pitch), 0);
        check("busy after done", int'(bus.busy), 0);

        // Looping: after 75 the song restarts at index 0 with no song_done.
        bus.loop_en = 1'b1;
        push_note(77, 0);
        push_note(75, 2);
        push_note(77, 0);
        start_song(0);
        do_tick();
        do_tick();
        do_tick();
        do_tick();
        do_tick();
        check("pitch held across loop", int'(bus.note_pitch), 75);
        check("busy across loop", int'(bus.busy), 1);
        cyc();
        check("loop pitch", int'(bus.note_pitch), 77);
        check("loop index", int'(bus.note_index), 0);

        // stop together with start during PLAY: stop wins, start is not remembered.
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check("busy after stop", int'(bus.busy), 0);
        check("pitch after stop", int'(bus.note_pitch), 0);
        cyc();
        cyc();
        check("no start after stop", int'(bus.busy), 0);
        bus.loop_en = 1'b0;

        // Pause freezes the countdown for 5 ticks.
        push_note(77, 0);
        start_song(0);
        do_tick();
        bus.pause = 1'b1;
        repeat (5) do_tick();
        check("pitch held in pause", int'(bus.note_pitch), 77);
        check("busy in pause", int'(bus.busy), 1);
        bus.pause = 1'b0;
        do_tick();
        check("rest after paused note", int'(bus.note_pitch), 0);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        check("busy after stop 2", int'(bus.busy), 0);

        // Asynchronous reset mid-note.
        push_note(77, 0);
        start_song(0);
        do_tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset pitch", int'(bus.note_pitch), 0);
        check("async reset busy", int'(bus.busy), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("idle after reset busy", int'(bus.busy), 0);
        check("idle after reset pitch", int'(bus.note_pitch), 0);

        // Full-length song without end marker: ends after the last slot, index never wraps.
        for (int i = 0; i < int'(MAX_NOTES); i++) begin
            push_note(60 + (i % 16), i);
        end
        push_done();
        start_song(1);
        repeat (int'(MAX_NOTES)) do_tick();
        check("last index held", int'(bus.note_index), int'(MAX_NOTES) - 1);
        check("busy after full song", int'(bus.busy), 0);
        check("pitch after full song", int'(bus.note_pitch), 0);
        cyc();
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
